// File: rtl/debug_frame_bridge.sv
// Bridge between the blaze command channel and the MIPS debug hooks.
// It decodes strobed command frames, runs the RUN/HALT/CAPTURE control FSM,
// loads instruction memory, and buffers debug words for read-back.
module debug_frame_bridge #(
  parameter int unsigned NB_FRAME = 32,
  parameter int unsigned NB_REG   = 32,
  parameter int unsigned N_WORDS  = 8,
  parameter int unsigned NB_PC    = 9
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_FRAME-1:0] i_frame_from_blaze,
  input  logic [NB_REG-1:0]   i_frame_from_mips,
  input  logic                i_eod,
  input  logic                i_eop,
  input  logic [NB_PC-1:0]    i_mips_pc,
  output logic [NB_FRAME-1:0] o_frame_to_blaze,
  output logic                o_valid,
  output logic                o_reset,
  output logic [NB_REG-1:0]   o_instr_data,
  output logic [15:0]         o_instr_addr,
  output logic [3:0]          o_instr_mem_we,
  output logic [5:0]          o_request_select,
  output logic                o_halted
);

  localparam int unsigned AW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned PW = 7;  // holds 0..N_WORDS inclusive
  localparam int unsigned TW = (NB_PC < 9) ? NB_PC : 9;

  localparam logic [5:0] CodeStart    = 6'h01;
  localparam logic [5:0] CodeReset    = 6'h02;
  localparam logic [5:0] CodeReqData  = 6'h03;
  localparam logic [5:0] CodeLoadLsb  = 6'h04;
  localparam logic [5:0] CodeLoadMsb  = 6'h05;
  localparam logic [5:0] CodeModeGet  = 6'h08;
  localparam logic [5:0] CodeModeCont = 6'h09;
  localparam logic [5:0] CodeModeStep = 6'h0A;
  localparam logic [5:0] CodeSetBp    = 6'h0C;
  localparam logic [5:0] CodeClrBp    = 6'h0D;
  localparam logic [5:0] CodeStep     = 6'h20;
  localparam logic [5:0] CodeGotData  = 6'h24;
  localparam logic [5:0] CodeGibData  = 6'h25;

  localparam logic [31:0] RspOk  = {6'h03, 26'b0};
  localparam logic [31:0] RspNok = {6'h02, 26'b0};
  localparam logic [31:0] RspEop = {6'h04, 26'b0};

  typedef enum logic [1:0] {StIdle, StRun, StHalt, StCapture} state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic                strobe_q;
  logic                cmd_pulse_q;
  logic [5:0]          cmd_code_q;
  logic [8:0]          cmd_type_q;
  logic [15:0]         cmd_data_q;
  logic [NB_FRAME-1:0] frame_q, frame_d;
  logic [5:0]          sel_q, sel_d;
  logic [3:0]          we_q, we_d;
  logic [NB_REG-1:0]   instr_data_q, instr_data_d;
  logic [15:0]         instr_addr_q, instr_addr_d;
  logic                mips_rst_q, mips_rst_d;
  logic                mode_step_q, mode_step_d;
  logic                bp_armed_q, bp_armed_d;
  logic [NB_PC-1:0]    bp_addr_q, bp_addr_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic                ovf_q, ovf_d;
  logic                mem_we;
  logic [NB_REG-1:0]   cap_mem_q [N_WORDS];

  logic valid;
  logic bp_hit;
  logic step_done;
  logic halt_evt;
  logic type_ok;
  logic [5:0] type_sel;

  // Pipeline advance and halted status follow directly from the FSM state.
  always_comb begin
    valid     = (state_q == StRun) && (!mode_step_q || (step_cnt_q != 16'd0));
    bp_hit    = bp_armed_q && valid && (i_mips_pc == bp_addr_q);
    // Last permitted step (or none at all) ends the run this cycle.
    step_done = (state_q == StRun) && mode_step_q && (step_cnt_q <= 16'd1);
    halt_evt  = (state_q == StRun) && (i_eop || bp_hit || step_done);
  end

  assign o_valid          = valid;
  assign o_halted         = (state_q == StHalt);
  assign o_frame_to_blaze = frame_q;
  assign o_request_select = sel_q;
  assign o_instr_mem_we   = we_q;
  assign o_instr_data     = instr_data_q;
  assign o_instr_addr     = instr_addr_q;
  assign o_reset          = mips_rst_q;

  // Map the REQ_DATA type field onto a source select code.
  always_comb begin
    type_ok  = 1'b1;
    type_sel = 6'h3F;
    if (cmd_type_q == 9'd0) begin
      type_sel = 6'h20;
    end else if (cmd_type_q == 9'd1) begin
      type_sel = 6'h21;
    end else if (cmd_type_q == 9'd2) begin
      type_sel = {1'b0, cmd_data_q[4:0]};
    end else if (cmd_type_q == 9'd3) begin
      type_sel = 6'h22;
    end else if ((cmd_type_q >= 9'd4) && (cmd_type_q <= 9'd11)) begin
      type_sel = 6'h20 + cmd_type_q[5:0];
    end else begin
      type_ok = 1'b0;
    end
  end

  // Next-state logic: run-time events first, then the accepted command.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    frame_d      = frame_q;
    sel_d        = 6'h3F;
    we_d         = 4'b0000;
    instr_data_d = instr_data_q;
    instr_addr_d = instr_addr_q;
    mips_rst_d   = 1'b0;
    mode_step_d  = mode_step_q;
    bp_armed_d   = bp_armed_q;
    bp_addr_d    = bp_addr_q;
    step_cnt_d   = step_cnt_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    ovf_d        = ovf_q;
    mem_we       = 1'b0;

    if (valid && mode_step_q) begin
      step_cnt_d = step_cnt_q - 16'd1;
    end

    if (state_q == StCapture) begin
      if (i_eod) begin
        state_d = ret_q;
      end else if (wptr_q < PW'(N_WORDS)) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 7'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Command responses override the end-of-program report.
    if (i_eop) begin
      frame_d = NB_FRAME'(RspEop);
    end

    if (cmd_pulse_q) begin
      frame_d = NB_FRAME'(RspOk);
      case (cmd_code_q)
        CodeStart: begin
          if ((state_q == StIdle) || (state_q == StHalt)) state_d = StRun;
        end
        CodeReset: begin
          state_d    = StIdle;
          step_cnt_d = 16'd0;
          mips_rst_d = 1'b1;
        end
        CodeReqData: begin
          if (((state_q == StIdle) || (state_q == StHalt)) && type_ok) begin
            sel_d   = type_sel;
            wptr_d  = '0;
            rptr_d  = '0;
            ovf_d   = 1'b0;
            ret_d   = state_q;
            state_d = StCapture;
          end else begin
            frame_d = NB_FRAME'(RspNok);
          end
        end
        CodeLoadLsb: begin
          we_d         = 4'b0011;
          instr_data_d = NB_REG'(cmd_data_q);
          instr_addr_d = 16'(cmd_type_q[TW-1:0]);
        end
        CodeLoadMsb: begin
          we_d         = 4'b1100;
          instr_data_d = NB_REG'({cmd_data_q, 16'h0000});
          instr_addr_d = 16'(cmd_type_q[TW-1:0]);
        end
        CodeModeGet: begin
          frame_d = NB_FRAME'({(mode_step_q ? CodeModeStep : CodeModeCont), 26'b0});
        end
        CodeModeCont: mode_step_d = 1'b0;
        CodeModeStep: mode_step_d = 1'b1;
        CodeSetBp: begin
          bp_addr_d  = cmd_data_q[NB_PC-1:0];
          bp_armed_d = 1'b1;
        end
        CodeClrBp: bp_armed_d = 1'b0;
        CodeStep: begin
          step_cnt_d = (cmd_data_q == 16'd0) ? 16'd1 : cmd_data_q;
          if (state_q == StHalt) state_d = StRun;
        end
        CodeGotData: begin
          if (state_q == StCapture) begin
            frame_d = NB_FRAME'({6'h02, 25'b0, ovf_q});
          end else begin
            frame_d = NB_FRAME'({6'h03, 20'b0, wptr_q[5:0]});
          end
        end
        CodeGibData: begin
          if (rptr_q < wptr_q) begin
            frame_d = NB_FRAME'(cap_mem_q[rptr_q[AW-1:0]]);
            rptr_d  = rptr_q + 7'd1;
          end else begin
            frame_d = NB_FRAME'(RspNok);
          end
        end
        default: frame_d = NB_FRAME'(RspNok);
      endcase
    end

    // A halt event still applies when a command lands on the same cycle.
    if (halt_evt && (state_d == StRun)) begin
      state_d = StHalt;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      ret_q        <= StIdle;
      strobe_q     <= 1'b0;
      cmd_pulse_q  <= 1'b0;
      cmd_code_q   <= '0;
      cmd_type_q   <= '0;
      cmd_data_q   <= '0;
      frame_q      <= '0;
      sel_q        <= 6'h3F;
      we_q         <= 4'b0000;
      instr_data_q <= '0;
      instr_addr_q <= '0;
      mips_rst_q   <= 1'b0;
      mode_step_q  <= 1'b0;
      bp_armed_q   <= 1'b0;
      bp_addr_q    <= '0;
      step_cnt_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      strobe_q     <= i_frame_from_blaze[25];
      cmd_pulse_q  <= i_frame_from_blaze[25] & ~strobe_q;
      if (i_frame_from_blaze[25] && !strobe_q) begin
        cmd_code_q <= i_frame_from_blaze[31:26];
        cmd_type_q <= i_frame_from_blaze[24:16];
        cmd_data_q <= i_frame_from_blaze[15:0];
      end
      state_q      <= state_d;
      ret_q        <= ret_d;
      frame_q      <= frame_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      instr_data_q <= instr_data_d;
      instr_addr_q <= instr_addr_d;
      mips_rst_q   <= mips_rst_d;
      mode_step_q  <= mode_step_d;
      bp_armed_q   <= bp_armed_d;
      bp_addr_q    <= bp_addr_d;
      step_cnt_q   <= step_cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      ovf_q        <= ovf_d;
    end
  end

  // Capture buffer storage; validity is tracked by the pointers only.
  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      cap_mem_q[wptr_q[AW-1:0]] <= i_frame_from_mips;
    end
  end

endmodule

// File: tb/tb_debug_frame_bridge.sv
// Directed self-checking bench for debug_frame_bridge.
module tb_debug_frame_bridge;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_frame_from_blaze;
  logic [31:0] i_frame_from_mips;
  logic        i_eod;
  logic        i_eop;
  logic [8:0]  i_mips_pc;
  logic [31:0] o_frame_to_blaze;
  logic        o_valid;
  logic        o_reset;
  logic [31:0] o_instr_data;
  logic [15:0] o_instr_addr;
  logic [3:0]  o_instr_mem_we;
  logic [5:0]  o_request_select;
  logic        o_halted;

  int checks   = 0;
  int failures = 0;
  int nv;

  debug_frame_bridge #(
    .NB_FRAME(32),
    .NB_REG  (32),
    .N_WORDS (8),
    .NB_PC   (9)
  ) dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_frame_from_blaze(i_frame_from_blaze),
    .i_frame_from_mips (i_frame_from_mips),
    .i_eod             (i_eod),
    .i_eop             (i_eop),
    .i_mips_pc         (i_mips_pc),
    .o_frame_to_blaze  (o_frame_to_blaze),
    .o_valid           (o_valid),
    .o_reset           (o_reset),
    .o_instr_data      (o_instr_data),
    .o_instr_addr      (o_instr_addr),
    .o_instr_mem_we    (o_instr_mem_we),
    .o_request_select  (o_request_select),
    .o_halted          (o_halted)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe low for a cycle, raise it, then return one cycle after the
  // command has been executed (response visible).
  task automatic send_cmd(input logic [5:0] code, input logic [8:0] typ, input logic [15:0] data);
    i_frame_from_blaze = 32'h0;
    @(posedge i_clock); #1;
    i_frame_from_blaze = {code, 1'b1, typ, data};
    @(posedge i_clock);
    @(posedge i_clock); #1;
    i_frame_from_blaze = 32'h0;
  endtask

  task automatic step_clk();
    @(posedge i_clock); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame"}, o_frame_to_blaze, 32'h0);
    check({tag, "_valid"}, 32'(o_valid), 32'h0);
    check({tag, "_oreset"}, 32'(o_reset), 32'h0);
    check({tag, "_we"}, 32'(o_instr_mem_we), 32'h0);
    check({tag, "_sel"}, 32'(o_request_select), 32'h3F);
    check({tag, "_halted"}, 32'(o_halted), 32'h0);
  endtask

  initial begin
    i_reset            = 1'b0;
    i_frame_from_blaze = 32'h0;
    i_frame_from_mips  = 32'h0;
    i_eod              = 1'b0;
    i_eop              = 1'b0;
    i_mips_pc          = 9'h0;
    repeat (3) step_clk();
    check_reset_outputs("por");
    i_reset = 1'b1;
    step_clk();

    // Unknown code: NOK, still idle.
    send_cmd(6'h3F, 9'h0, 16'h0);
    check("unk_nok", o_frame_to_blaze, 32'h0800_0000);
    check("unk_valid", 32'(o_valid), 32'h0);
    check("unk_halted", 32'(o_halted), 32'h0);
    send_cmd(6'h08, 9'h0, 16'h0);
    check("mode_get_cont", o_frame_to_blaze, 32'h2400_0000);

    // Instruction memory loads.
    send_cmd(6'h04, 9'd5, 16'h1234);
    check("lsb_we", 32'(o_instr_mem_we), 32'h3);
    check("lsb_data", o_instr_data, 32'h0000_1234);
    check("lsb_addr", 32'(o_instr_addr), 32'h5);
    check("lsb_rsp", o_frame_to_blaze, 32'h0C00_0000);
    step_clk();
    check("lsb_we_pulse", 32'(o_instr_mem_we), 32'h0);
    send_cmd(6'h05, 9'd5, 16'hABCD);
    check("msb_we", 32'(o_instr_mem_we), 32'hC);
    check("msb_data", o_instr_data, 32'hABCD_0000);
    check("msb_addr", 32'(o_instr_addr), 32'h5);

    // Step mode: START with no steps halts immediately, STEP 3 gives 3 cycles.
    send_cmd(6'h0A, 9'h0, 16'h0);
    send_cmd(6'h08, 9'h0, 16'h0);
    check("mode_get_step", o_frame_to_blaze, 32'h2800_0000);
    send_cmd(6'h01, 9'h0, 16'h0);
    check("start_step_valid", 32'(o_valid), 32'h0);
    step_clk();
    check("start_step_halt", 32'(o_halted), 32'h1);
    send_cmd(6'h20, 9'h0, 16'd3);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) nv++;
      step_clk();
    end
    check("step3_count", 32'(nv), 32'd3);
    check("step3_halted", 32'(o_halted), 32'h1);
    send_cmd(6'h20, 9'h0, 16'd0);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_valid) nv++;
      step_clk();
    end
    check("step0_count", 32'(nv), 32'd1);

    // Breakpoint in continuous mode.
    send_cmd(6'h09, 9'h0, 16'h0);
    send_cmd(6'h0C, 9'h0, 16'h0010);
    check("setbp_rsp", o_frame_to_blaze, 32'h0C00_0000);
    i_mips_pc = 9'h0;
    send_cmd(6'h01, 9'h0, 16'h0);
    nv = 0;
    for (int p = 0; p < 16; p++) begin
      i_mips_pc = 9'(p);
      if (o_valid) nv++;
      step_clk();
    end
    check("bp_ramp_valid", 32'(nv), 32'd16);
    i_mips_pc = 9'h10;
    check("bp_hit_valid", 32'(o_valid), 32'h1);
    step_clk();
    check("bp_after_valid", 32'(o_valid), 32'h0);
    check("bp_after_halted", 32'(o_halted), 32'h1);

    // EOP reporting versus command response.
    i_eop = 1'b1;
    step_clk();
    check("eop_rsp", o_frame_to_blaze, 32'h1000_0000);
    send_cmd(6'h08, 9'h0, 16'h0);
    check("eop_cmd_wins", o_frame_to_blaze, 32'h2400_0000);
    step_clk();
    check("eop_again", o_frame_to_blaze, 32'h1000_0000);
    i_eop = 1'b0;

    // RESET command.
    send_cmd(6'h02, 9'h0, 16'h0);
    check("rst_pulse", 32'(o_reset), 32'h1);
    check("rst_halted", 32'(o_halted), 32'h0);
    step_clk();
    check("rst_pulse_end", 32'(o_reset), 32'h0);

    // Capture of a latch group with overflow.
    send_cmd(6'h03, 9'd4, 16'h0);
    check("req_sel", 32'(o_request_select), 32'h24);
    check("req_rsp", o_frame_to_blaze, 32'h0C00_0000);
    for (int i = 0; i < 10; i++) begin
      i_frame_from_mips = 32'hC0DE_0000 + 32'(i);
      step_clk();
    end
    check("req_sel_end", 32'(o_request_select), 32'h3F);
    send_cmd(6'h24, 9'h0, 16'h0);
    check("got_busy_ovf", o_frame_to_blaze, 32'h0800_0001);
    i_eod = 1'b1;
    step_clk();
    i_eod = 1'b0;
    send_cmd(6'h24, 9'h0, 16'h0);
    check("got_ok_count", o_frame_to_blaze, 32'h0C00_0008);
    for (int i = 0; i < 8; i++) begin
      send_cmd(6'h25, 9'h0, 16'h0);
      check("gib_word", o_frame_to_blaze, 32'hC0DE_0000 + 32'(i));
    end
    send_cmd(6'h25, 9'h0, 16'h0);
    check("gib_9th_nok", o_frame_to_blaze, 32'h0800_0000);

    // Register request select, then i_reset in the middle of capture.
    send_cmd(6'h03, 9'd2, 16'h0005);
    check("req_reg_sel", 32'(o_request_select), 32'h05);
    for (int i = 0; i < 3; i++) begin
      i_frame_from_mips = 32'h5500_0000 + 32'(i);
      step_clk();
    end
    i_reset = 1'b0;
    step_clk();
    check_reset_outputs("midcap");
    i_reset = 1'b1;
    step_clk();
    send_cmd(6'h25, 9'h0, 16'h0);
    check("midcap_gib_nok", o_frame_to_blaze, 32'h0800_0000);
    send_cmd(6'h24, 9'h0, 16'h0);
    check("midcap_got", o_frame_to_blaze, 32'h0C00_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_frame_bridge.md
DEBUG_FRAME_BRIDGE -- requirements
Module: debug_frame_bridge

Parameters
REQ-001 SHALL have parameter NB_FRAME, default 32: width of blaze command/response frames.
REQ-002 SHALL have parameter NB_REG, default 32: width of a MIPS debug word.
REQ-003 SHALL have parameter N_WORDS, default 8, range 2..64: capture buffer depth in words.
REQ-004 SHALL have parameter NB_PC, default 9: instruction address width, at most 16.

Interface
REQ-005 SHALL have port i_clock, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-006 SHALL have port i_reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port i_frame_from_blaze, input, NB_FRAME bits, with fields [31:26] code, [25] command strobe, [24:16] type, [15:0] data.
REQ-008 SHALL have port i_frame_from_mips, input, NB_REG bits: debug word streamed by the selected source.
REQ-009 SHALL have port i_eod, input, 1 bit: end of data, high on the cycle after the last word.
REQ-010 SHALL have port i_eop, input, 1 bit: MIPS end of program.
REQ-011 SHALL have port i_mips_pc, input, NB_PC bits: current fetch PC.
REQ-012 SHALL have port o_frame_to_blaze, output, NB_FRAME bits: registered response.
REQ-013 SHALL have port o_valid, output, 1 bit: pipeline advance enable.
REQ-014 SHALL have port o_reset, output, 1 bit: one-cycle MIPS reset pulse.
REQ-015 SHALL have port o_instr_data, output, NB_REG bits: instruction write data.
REQ-016 SHALL have port o_instr_addr, output, 16 bits: instruction write address.
REQ-017 SHALL have port o_instr_mem_we, output, 4 bits: byte write enables.
REQ-018 SHALL have port o_request_select, output, 6 bits: selected data source; 6'h3F means none.
REQ-019 SHALL have port o_halted, output, 1 bit: high when the MIPS is stopped by step exhaustion, breakpoint or EOP.

Function
REQ-020 SHALL accept a command only on the cycle after a 0->1 transition of strobe bit 25 (registered edge detect), ignoring other cycles.
REQ-021 SHALL decode codes: START 01, RESET 02, REQ_DATA 03, LOAD_LSB 04, LOAD_MSB 05, MODE_GET 08, MODE_CONT 09, MODE_STEP 0A, SET_BP 0C, CLR_BP 0D, STEP 20, GOT_DATA 24, GIB_DATA 25 (hex), treating any other code as no-op answered with NOK.
REQ-022 SHALL run a state machine with states IDLE, RUN, HALT, CAPTURE.
REQ-023 SHALL move IDLE->RUN on START, RUN->HALT on step exhaustion, breakpoint hit or i_eop, HALT->RUN on START or STEP, and any state->IDLE on RESET.
REQ-024 SHALL, on REQ_DATA, drive o_request_select from the type-field LUT (mem data 20, mem instr 21, reg {0,data[4:0]}, PC 22, latches 24..2B) for exactly one cycle, then enter CAPTURE from IDLE or HALT, or answer NOK from RUN.
REQ-025 SHALL, in CAPTURE, write i_frame_from_mips to buffer[wptr] each cycle with wptr incrementing, and return to the prior state when i_eod is seen.
REQ-026 SHALL, when wptr reaches N_WORDS before i_eod, discard further words, set a sticky overflow flag, and not wrap wptr.
REQ-027 SHALL answer GIB_DATA with buffer[rptr] and then increment rptr while rptr < wptr, otherwise answer NOK; REQ_DATA clears rptr, wptr and overflow.
REQ-028 SHALL answer GOT_DATA with OK {6'h03, 20'b0, wptr[5:0]} when capture is complete, or with NOK {6'h02, 25'b0, overflow} while still capturing.
REQ-029 SHALL, in step mode, load a step counter from STEP data (value 0 treated as 1) and hold o_valid high one cycle per decrement until the counter reaches 0, then go to HALT.
REQ-030 SHALL, in continuous mode, hold o_valid high throughout RUN.
REQ-031 SHALL, with the breakpoint armed, halt when i_mips_pc equals bp_addr while o_valid is high, deasserting o_valid on the following cycle.
REQ-032 SHALL, on SET_BP, load bp_addr from data[NB_PC-1:0] and arm it; CLR_BP disarms it.
REQ-033 SHALL drive o_instr_mem_we 4'b0011 for LOAD_LSB and 4'b1100 for LOAD_MSB for one cycle, with data in the matching half of o_instr_data and o_instr_addr = type[NB_PC-1:0].
REQ-034 SHALL answer MODE_GET with {MODE_CONT or MODE_STEP code, 26'b0}.
REQ-035 SHALL, when i_eop is high, report EOP {6'h04, 26'b0}, which takes priority over IDLE but not over a command response.
REQ-036 SHALL, when a command is accepted on the same cycle as i_eop or a breakpoint hit, execute the command and halt as well.

Reset
REQ-037 SHALL, when i_reset=0, reset to IDLE with o_frame_to_blaze=0, o_valid=0, o_reset=0, o_instr_mem_we=0, o_request_select=6'h3F, o_halted=0, all pointers, counters and flags cleared, breakpoint disarmed, and continuous mode.
REQ-038 SHALL abort capture on a reset during CAPTURE, making the buffer contents unreadable (GIB_DATA answers NOK).
REQ-039 SHALL pulse o_reset for one cycle on the RESET command and clear the run state and step counter.

Verification
REQ-040 SHALL be verified by: LOAD_LSB then LOAD_MSB to type 5, data 1234/ABCD -> we 0011 then 1100, addr 5.
REQ-041 SHALL be verified by: MODE_STEP, START, STEP data 3 -> exactly 3 o_valid cycles, then HALT with o_halted=1.
REQ-042 SHALL be verified by: SET_BP 0x10, continuous START with PC ramp -> o_valid drops the cycle after PC=0x10.
REQ-043 SHALL be verified by: REQ_DATA latch group with N_WORDS=8 and 10 words before i_eod -> GOT_DATA OK count 8, overflow=1, the 9th GIB_DATA answers NOK.
REQ-044 SHALL be verified by: i_reset low mid-capture -> all outputs at reset values and GIB_DATA answers NOK.
REQ-045 SHALL be verified by: unknown code 3F -> NOK response and no state change.
